// File: rtl/hex_display_ctrl.sv
// N-digit hex 7-segment controller: shadow capture with hold, leading-zero
// blanking, per-digit blink, static pins and a scanned (multiplexed) output.
module hex_display_ctrl #(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 25000,
    parameter int BLINK_DIV     = 12500000,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  latch,
    input  logic                  hold,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   seg_static,
    output logic [6:0]            seg_mux,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_tick
);

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [BCW-1:0] BL_LAST = BCW'(BLINK_DIV - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(DIGITS - 1);

    localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {
        SLOT_BLANK,
        SLOT_ON
    } slot_e;

    slot_e                r_slot;
    logic [4*DIGITS-1:0]  r_shadow;
    logic [7*DIGITS-1:0]  r_seg_static;
    logic [6:0]           r_seg_mux;
    logic [DIGITS-1:0]    r_dig_sel;
    logic                 r_frame_tick;
    logic [SCW-1:0]       r_scan_cnt;
    logic [IDW-1:0]       r_dig_idx;
    logic [BCW-1:0]       r_blink_cnt;
    logic                 r_blink_phase;

    logic                 w_run;
    logic [DIGITS-1:0]    w_blank;
    logic [6:0]           w_glyph [DIGITS];
    logic [7*DIGITS-1:0]  w_seg_nxt;
    logic                 w_scan_wrap;
    logic [SCW-1:0]       w_scan_cnt_nxt;
    logic [IDW-1:0]       w_dig_idx_nxt;
    logic [DIGITS-1:0]    w_onehot;
    logic [DIGITS-1:0]    w_sel_on;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    // Walk from the most significant digit down; w_run stays set while all
    // nibbles seen so far are zero.
    always_comb begin
        w_run     = 1'b1;
        w_blank   = '0;
        w_seg_nxt = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_run = w_run && (r_shadow[4*k +: 4] == 4'h0);
            w_blank[k] = ((BLANK_LEADING != 0) && w_run && (k != 0))
                       || (r_blink_phase && blink_mask[k]);
            w_glyph[k] = w_blank[k] ? SEG_OFF
                       : ((ACTIVE_LOW != 0) ? ~hex_glyph(r_shadow[4*k +: 4])
                                            : hex_glyph(r_shadow[4*k +: 4]));
            w_seg_nxt[7*k +: 7] = w_glyph[k];
        end
    end

    always_comb begin
        w_scan_wrap    = (r_scan_cnt == SC_LAST);
        w_scan_cnt_nxt = w_scan_wrap ? '0 : r_scan_cnt + SCW'(1);
        w_dig_idx_nxt  = r_dig_idx;
        if (w_scan_wrap) begin
            w_dig_idx_nxt = (r_dig_idx == ID_LAST) ? '0 : r_dig_idx + IDW'(1);
        end
        w_onehot = DIGITS'(1) << w_dig_idx_nxt;
        w_sel_on = (ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow     <= '0;
            r_seg_static <= {DIGITS{SEG_OFF}};
        end else begin
            if (latch && !hold) begin
                r_shadow <= value_in;
            end
            r_seg_static <= w_seg_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BL_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BCW'(1);
        end
    end

    // Outputs are registered from next-state values so dig_sel/seg_mux line
    // up with the counters they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot       <= SLOT_BLANK;
            r_scan_cnt   <= '0;
            r_dig_idx    <= '0;
            r_dig_sel    <= SEL_OFF;
            r_seg_mux    <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_scan_cnt   <= w_scan_cnt_nxt;
            r_dig_idx    <= w_dig_idx_nxt;
            r_seg_mux    <= w_glyph[w_dig_idx_nxt];
            r_frame_tick <= w_scan_wrap && (w_dig_idx_nxt == '0);
            case (r_slot)
                SLOT_BLANK: begin
                    r_slot    <= SLOT_ON;
                    r_dig_sel <= w_sel_on;
                end
                default: begin
                    if (w_scan_wrap) begin
                        r_slot    <= SLOT_BLANK;
                        r_dig_sel <= SEL_OFF;
                    end else begin
                        r_slot    <= SLOT_ON;
                        r_dig_sel <= w_sel_on;
                    end
                end
            endcase
        end
    end

    assign seg_static = r_seg_static;
    assign seg_mux    = r_seg_mux;
    assign dig_sel    = r_dig_sel;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: an active-low scanned instance and an
// active-high leading-blank instance driven from the same stimulus.
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        latch;
    logic        hold;
    logic [3:0]  blink_mask;

    logic [27:0] a_seg;
    logic [6:0]  a_mux;
    logic [3:0]  a_sel;
    logic        a_tick;
    logic [27:0] b_seg;
    logic [6:0]  b_mux;
    logic [3:0]  b_sel;
    logic        b_tick;

    int checks = 0;
    int errors = 0;

    localparam logic [27:0] A_1A2F = {~7'h06, ~7'h77, ~7'h5B, ~7'h71};
    localparam logic [27:0] B_1A2F = {7'h06, 7'h77, 7'h5B, 7'h71};
    localparam logic [27:0] A_1234 = {~7'h06, ~7'h5B, ~7'h4F, ~7'h66};

    logic [6:0] ga [4];

    always #5 clk = ~clk;

    hex_display_ctrl #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8),
        .ACTIVE_LOW(1), .BLANK_LEADING(0)
    ) u_a (
        .clk(clk), .rst(rst), .value_in(value_in), .latch(latch),
        .hold(hold), .blink_mask(blink_mask), .seg_static(a_seg),
        .seg_mux(a_mux), .dig_sel(a_sel), .frame_tick(a_tick)
    );

    hex_display_ctrl #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8),
        .ACTIVE_LOW(0), .BLANK_LEADING(1)
    ) u_b (
        .clk(clk), .rst(rst), .value_in(value_in), .latch(latch),
        .hold(hold), .blink_mask(blink_mask), .seg_static(b_seg),
        .seg_mux(b_mux), .dig_sel(b_sel), .frame_tick(b_tick)
    );

    task automatic do_reset();
        rst = 1'b1;
        latch = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic latch_val(input logic [15:0] v);
        value_in = v;
        latch = 1'b1;
        @(negedge clk);
        latch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks += 8;
        if (a_seg !== 28'hFFFFFFF) begin
            errors++; $display("FAIL reset a_seg got %h exp %h", a_seg, 28'hFFFFFFF);
        end
        if (a_mux !== 7'h7F) begin
            errors++; $display("FAIL reset a_mux got %h exp 7f", a_mux);
        end
        if (a_sel !== 4'hF) begin
            errors++; $display("FAIL reset a_sel got %h exp f", a_sel);
        end
        if (a_tick !== 1'b0) begin
            errors++; $display("FAIL reset a_tick got %b exp 0", a_tick);
        end
        if (b_seg !== 28'h0) begin
            errors++; $display("FAIL reset b_seg got %h exp 0", b_seg);
        end
        if (b_mux !== 7'h00) begin
            errors++; $display("FAIL reset b_mux got %h exp 0", b_mux);
        end
        if (b_sel !== 4'h0) begin
            errors++; $display("FAIL reset b_sel got %h exp 0", b_sel);
        end
        if (b_tick !== 1'b0) begin
            errors++; $display("FAIL reset b_tick got %b exp 0", b_tick);
        end
        rst = 1'b0;
    endtask

    task automatic test_capture();
        latch_val(16'h1A2F);
        checks += 3;
        if (a_seg !== {4{~7'h3F}}) begin
            errors++; $display("FAIL capture_latency a_seg got %h exp %h", a_seg, {4{~7'h3F}});
        end
        @(negedge clk);
        if (a_seg !== A_1A2F) begin
            errors++; $display("FAIL capture a_seg got %h exp %h", a_seg, A_1A2F);
        end
        if (b_seg !== B_1A2F) begin
            errors++; $display("FAIL capture b_seg got %h exp %h", b_seg, B_1A2F);
        end
    endtask

    task automatic test_hold();
        latch_val(16'h1234);
        @(negedge clk);
        hold = 1'b1;
        latch = 1'b1;
        value_in = 16'hFFFF;
        repeat (3) @(negedge clk);
        checks += 2;
        if (a_seg !== A_1234) begin
            errors++; $display("FAIL hold_over_latch a_seg got %h exp %h", a_seg, A_1234);
        end
        hold = 1'b0;
        latch = 1'b0;
        repeat (2) @(negedge clk);
        if (a_seg !== A_1234) begin
            errors++; $display("FAIL no_latch a_seg got %h exp %h", a_seg, A_1234);
        end
    endtask

    task automatic test_blank_leading();
        latch_val(16'h0040);
        @(negedge clk);
        checks += 4;
        if (b_seg !== {7'h00, 7'h00, 7'h66, 7'h3F}) begin
            errors++; $display("FAIL lz_0040 b_seg got %h", b_seg);
        end
        if (a_seg !== {~7'h3F, ~7'h3F, ~7'h66, ~7'h3F}) begin
            errors++; $display("FAIL nolz_0040 a_seg got %h", a_seg);
        end
        latch_val(16'h0000);
        @(negedge clk);
        if (b_seg !== {21'h0, 7'h3F}) begin
            errors++; $display("FAIL lz_0000 b_seg got %h exp %h", b_seg, {21'h0, 7'h3F});
        end
        latch_val(16'h1004);
        @(negedge clk);
        if (b_seg !== {7'h06, 7'h3F, 7'h3F, 7'h66}) begin
            errors++; $display("FAIL lz_1004 b_seg got %h", b_seg);
        end
    endtask

    task automatic test_scan();
        logic [3:0] one;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        int cnt;
        int idx;
        blink_mask = 4'b0000;
        do_reset();
        latch_val(16'h1A2F);
        for (int t = 2; t <= 40; t++) begin
            @(negedge clk);
            cnt = t % 4;
            idx = (t / 4) % 4;
            one = 4'b0001 << idx;
            exp_a = (cnt == 0) ? 4'hF : ~one;
            exp_b = (cnt == 0) ? 4'h0 : one;
            checks += 4;
            if (a_sel !== exp_a) begin
                errors++; $display("FAIL scan_sel t=%0d a_sel got %b exp %b", t, a_sel, exp_a);
            end
            if (b_sel !== exp_b) begin
                errors++; $display("FAIL scan_sel t=%0d b_sel got %b exp %b", t, b_sel, exp_b);
            end
            if (a_tick !== (t % 16 == 0)) begin
                errors++; $display("FAIL frame_tick t=%0d got %b", t, a_tick);
            end
            if (a_mux !== ga[idx]) begin
                errors++; $display("FAIL seg_mux t=%0d got %h exp %h", t, a_mux, ga[idx]);
            end
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_a0;
        logic [6:0] exp_b0;
        int ph;
        blink_mask = 4'b0001;
        do_reset();
        latch_val(16'h1A2F);
        for (int t = 2; t <= 40; t++) begin
            @(negedge clk);
            ph = ((t - 1) / 8) % 2;
            exp_a0 = (ph == 1) ? 7'h7F : ~7'h71;
            exp_b0 = (ph == 1) ? 7'h00 : 7'h71;
            checks += 3;
            if (a_seg[6:0] !== exp_a0) begin
                errors++; $display("FAIL blink_d0 t=%0d a got %h exp %h", t, a_seg[6:0], exp_a0);
            end
            if (b_seg[6:0] !== exp_b0) begin
                errors++; $display("FAIL blink_d0 t=%0d b got %h exp %h", t, b_seg[6:0], exp_b0);
            end
            if (a_seg[27:7] !== A_1A2F[27:7]) begin
                errors++; $display("FAIL blink_steady t=%0d got %h", t, a_seg[27:7]);
            end
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_reset_mid();
        logic [3:0] one;
        logic [3:0] exp_a;
        int cnt;
        int idx;
        do_reset();
        latch_val(16'h1A2F);
        repeat (9) @(negedge clk);
        checks += 5;
        if (a_sel !== 4'hB) begin
            errors++; $display("FAIL mid_pre a_sel got %b exp 1011", a_sel);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (a_sel !== 4'hF) begin
            errors++; $display("FAIL mid_rst a_sel got %b exp 1111", a_sel);
        end
        if (a_mux !== 7'h7F) begin
            errors++; $display("FAIL mid_rst a_mux got %h exp 7f", a_mux);
        end
        if (a_seg !== 28'hFFFFFFF) begin
            errors++; $display("FAIL mid_rst a_seg got %h", a_seg);
        end
        if (a_tick !== 1'b0) begin
            errors++; $display("FAIL mid_rst a_tick got %b exp 0", a_tick);
        end
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk);
            cnt = t % 4;
            idx = (t / 4) % 4;
            one = 4'b0001 << idx;
            exp_a = (cnt == 0) ? 4'hF : ~one;
            checks += 2;
            if (a_sel !== exp_a) begin
                errors++; $display("FAIL mid_restart t=%0d a_sel got %b exp %b", t, a_sel, exp_a);
            end
            if (a_mux !== ~7'h3F) begin
                errors++; $display("FAIL mid_restart t=%0d a_mux got %h exp 40", t, a_mux);
            end
        end
    endtask

    initial begin
        ga[0] = ~7'h71;
        ga[1] = ~7'h5B;
        ga[2] = ~7'h77;
        ga[3] = ~7'h06;
        rst = 1'b1;
        value_in = 16'h0;
        latch = 1'b0;
        hold = 1'b0;
        blink_mask = 4'b0000;
        test_reset();
        test_capture();
        test_hold();
        test_blank_leading();
        test_scan();
        test_blink();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
